// File: rtl/me_pkg.sv
// me_pkg: shared motion-estimation types and state encodings for the pel delay line
package me_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_PRIMED  = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_e;

endpackage

// File: rtl/pel_delay_line_if.sv
// pel_delay_line_if: pel stream, tap select and fill-status bundle for pel_delay_line
interface pel_delay_line_if
    import me_pkg::*;
#(
    parameter int DEPTH_MAX = 16,
    parameter int DWIDTH    = 8,
    parameter int LANES     = 4
) ();

    localparam int AW = $clog2(DEPTH_MAX);

    logic                    en;
    logic                    flush;
    logic [LANES*DWIDTH-1:0] d;
    logic                    d_valid;
    logic [AW-1:0]           tap_sel;
    logic [LANES*DWIDTH-1:0] q;
    logic                    q_valid;
    logic                    primed;
    state_e                  state;

    modport master (
        output en, flush, d, d_valid, tap_sel,
        input  q, q_valid, primed, state
    );

    modport slave (
        input  en, flush, d, d_valid, tap_sel,
        output q, q_valid, primed, state
    );

endinterface

// File: rtl/pel_delay_ctrl.sv
// pel_delay_ctrl: fill FSM, saturating fill counter and latched tap depth for pel_delay_line
module pel_delay_ctrl
    import me_pkg::*;
#(
    parameter int DEPTH_MAX = 16,
    parameter int AW        = $clog2(DEPTH_MAX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          flush,
    input  logic [AW-1:0] tap_sel,
    output logic [AW-1:0] tap,
    output logic          primed,
    output state_e        state
);

    localparam int CW = $clog2(DEPTH_MAX + 1);

    logic [CW-1:0] cnt;
    logic [AW-1:0] tap_clamp;
    logic [AW-1:0] dsel;
    logic [CW:0]   d_cur;
    logic [CW:0]   cnt_inc;
    logic          reach;

    // While EMPTY the requested depth is live so the first shift already uses it
    always_comb begin
        tap_clamp = (int'(tap_sel) >= DEPTH_MAX) ? AW'(DEPTH_MAX - 1) : tap_sel;
        dsel      = (state == ST_EMPTY) ? tap_clamp : tap;
        d_cur     = (CW+1)'(dsel) + (CW+1)'(1);
        cnt_inc   = {1'b0, cnt} + (CW+1)'(1);
        reach     = (state == ST_PRIMED) || (cnt_inc >= d_cur);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_EMPTY;
            cnt    <= '0;
            tap    <= AW'(DEPTH_MAX - 1);
            primed <= 1'b0;
        end else if (flush || state == ST_ILLEGAL) begin
            state  <= ST_EMPTY;
            cnt    <= '0;
            primed <= 1'b0;
        end else begin
            if (state == ST_EMPTY)
                tap <= tap_clamp;
            if (en) begin
                cnt    <= CW'((cnt_inc > d_cur) ? d_cur : cnt_inc);
                state  <= reach ? ST_PRIMED : ST_FILLING;
                primed <= reach;
            end
        end
    end

endmodule

// File: rtl/pel_delay_line.sv
// pel_delay_line: multi-lane programmable pel delay line with valid tracking and fill status.
// Define PEL_DELAY_LINE_TAPS_EN to expose every stage on the taps port.
module pel_delay_line
    import me_pkg::*;
#(
    parameter int DEPTH_MAX = 16,
    parameter int DWIDTH    = 8,
    parameter int LANES     = 4
) (
    input logic clk,
    input logic rst_n,
`ifdef PEL_DELAY_LINE_TAPS_EN
    pel_delay_line_if.slave bus,
    output logic [DEPTH_MAX*LANES*DWIDTH-1:0] taps
`else
    pel_delay_line_if.slave bus
`endif
);

    localparam int W  = LANES * DWIDTH;
    localparam int AW = $clog2(DEPTH_MAX);

    logic [W-1:0]         core [DEPTH_MAX];
    logic [DEPTH_MAX-1:0] vld;
    logic [AW-1:0]        tap;

    pel_delay_ctrl #(.DEPTH_MAX(DEPTH_MAX)) u_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (bus.en),
        .flush   (bus.flush),
        .tap_sel (bus.tap_sel),
        .tap     (tap),
        .primed  (bus.primed),
        .state   (bus.state)
    );

    // Flush only invalidates; pel contents stay so no wide clear is needed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH_MAX; k++)
                core[k] <= '0;
            vld <= '0;
        end else if (bus.flush) begin
            vld <= '0;
        end else if (bus.en) begin
            core[0] <= bus.d;
            for (int k = 1; k < DEPTH_MAX; k++)
                core[k] <= core[k-1];
            vld <= {vld[DEPTH_MAX-2:0], bus.d_valid};
        end
    end

    assign bus.q       = core[tap];
    assign bus.q_valid = vld[tap];

`ifdef PEL_DELAY_LINE_TAPS_EN
    for (genvar k = 0; k < DEPTH_MAX; k++)
        assign taps[k*W +: W] = core[k];
`endif

endmodule

// File: tb/tb_pel_delay_line.sv
// tb_pel_delay_line: directed table, corner sequences and random traffic against a queue model
module tb_pel_delay_line;
    import me_pkg::*;

    localparam int DEPTH_MAX = 16;
    localparam int DWIDTH    = 8;
    localparam int LANES     = 4;
    localparam int W         = LANES * DWIDTH;
    localparam int AW        = $clog2(DEPTH_MAX);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pel_delay_line_if #(.DEPTH_MAX(DEPTH_MAX), .DWIDTH(DWIDTH), .LANES(LANES)) bus ();

`ifdef PEL_DELAY_LINE_TAPS_EN
    logic [DEPTH_MAX*W-1:0] taps;
    pel_delay_line #(.DEPTH_MAX(DEPTH_MAX), .DWIDTH(DWIDTH), .LANES(LANES)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .taps(taps));
`else
    pel_delay_line #(.DEPTH_MAX(DEPTH_MAX), .DWIDTH(DWIDTH), .LANES(LANES)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    always #5 clk = ~clk;

    // Reference: history of accepted pels, newest first; depth fixed while non-empty
    logic [W-1:0] mh[$];
    bit           mv[$];
    int           fills;
    int           md;

    typedef struct {
        logic          en, fl;
        logic [7:0]    d;
        logic          dv;
        logic [AW-1:0] tap;
        logic [7:0]    q;
        logic          qv, pr;
        logic [1:0]    st;
    } vec_t;

    vec_t tv[13];

    function automatic vec_t v(int en, int fl, int d, int dv, int tap, int q, int qv, int pr, int st);
        vec_t r;
        r.en = 1'(en); r.fl = 1'(fl); r.d = 8'(d); r.dv = 1'(dv); r.tap = AW'(tap);
        r.q = 8'(q); r.qv = 1'(qv); r.pr = 1'(pr); r.st = 2'(st);
        return r;
    endfunction

    function automatic logic [W-1:0] rep(input logic [7:0] b);
        return {LANES{b}};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mh.delete();
        mv.delete();
        repeat (DEPTH_MAX) begin
            mh.push_back('0);
            mv.push_back(1'b0);
        end
        fills = 0;
        md    = DEPTH_MAX;
    endtask

    task automatic cycle(input logic en, input logic fl, input logic [W-1:0] d, input logic dv,
                         input logic [AW-1:0] tap);
        int sst;
        bus.en = en; bus.flush = fl; bus.d = d; bus.d_valid = dv; bus.tap_sel = tap;
        @(posedge clk);
        if (fl) begin
            foreach (mv[k]) mv[k] = 1'b0;
            fills = 0;
        end else begin
            if (fills == 0) md = (int'(tap) >= DEPTH_MAX) ? DEPTH_MAX : int'(tap) + 1;
            if (en) begin
                mh.push_front(d);  void'(mh.pop_back());
                mv.push_front(dv); void'(mv.pop_back());
                fills++;
            end
        end
        #1;
        sst = (fills == 0) ? 0 : (fills >= md) ? 2 : 1;
        chk("q", 64'(bus.q), 64'(mh[md-1]));
        chk("q_valid", 64'(bus.q_valid), 64'(mv[md-1]));
        chk("primed", 64'(bus.primed), 64'(fills >= md));
        chk("state", 64'(bus.state), 64'(sst));
        chk("cnt", 64'(dut.u_ctrl.cnt), 64'((fills < md) ? fills : md));
`ifdef PEL_DELAY_LINE_TAPS_EN
        chk("taps0", 64'(taps[W-1:0]), 64'(mh[0]));
`endif
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        chk("rst.q", 64'(bus.q), 64'(0));
        chk("rst.q_valid", 64'(bus.q_valid), 64'(0));
        chk("rst.primed", 64'(bus.primed), 64'(0));
        chk("rst.state", 64'(bus.state), 64'(ST_EMPTY));
        model_reset();
        bus.en = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [AW-1:0] rtap;
        bus.en = 1'b0; bus.flush = 1'b0; bus.d = '0; bus.d_valid = 1'b0; bus.tap_sel = '0;
        model_reset();
        #2;
        async_reset();

        // Directed table: D=4 fill with gaps, ignored tap change, flush+en, D=1 boundary
        tv[0]  = v(0, 0, 'h10, 1, 3, 'h00, 0, 0, 0);
        tv[1]  = v(1, 0, 'h11, 1, 3, 'h00, 0, 0, 1);
        tv[2]  = v(1, 0, 'h12, 1, 7, 'h00, 0, 0, 1);
        tv[3]  = v(0, 0, 'h13, 1, 7, 'h00, 0, 0, 1);
        tv[4]  = v(1, 0, 'h14, 1, 7, 'h00, 0, 0, 1);
        tv[5]  = v(1, 0, 'h15, 1, 7, 'h11, 1, 1, 2);
        tv[6]  = v(1, 1, 'hAA, 1, 7, 'h11, 0, 0, 0);
        tv[7]  = v(0, 0, 'h30, 1, 7, 'h00, 0, 0, 0);
        tv[8]  = v(1, 0, 'h20, 1, 7, 'h00, 0, 0, 1);
        tv[9]  = v(0, 1, 'h21, 1, 0, 'h00, 0, 0, 0);
        tv[10] = v(0, 0, 'h22, 1, 0, 'h20, 0, 0, 0);
        tv[11] = v(1, 0, 'h5A, 1, 0, 'h5A, 1, 1, 2);
        tv[12] = v(1, 0, 'h5B, 0, 0, 'h5B, 0, 1, 2);
        for (int i = 0; i < 13; i++) begin
            cycle(tv[i].en, tv[i].fl, rep(tv[i].d), tv[i].dv, tv[i].tap);
            chk($sformatf("tv%0d.q", i), 64'(bus.q), 64'(rep(tv[i].q)));
            chk($sformatf("tv%0d.q_valid", i), 64'(bus.q_valid), 64'(tv[i].qv));
            chk($sformatf("tv%0d.primed", i), 64'(bus.primed), 64'(tv[i].pr));
            chk($sformatf("tv%0d.state", i), 64'(bus.state), 64'(tv[i].st));
        end

        // D=16 ramp: first pel emerges with primed after the 16th enable
        async_reset();
        cycle(1'b0, 1'b0, '0, 1'b0, AW'(15));
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, rep(8'(i)), 1'b1, AW'(15));
            if (i == 14) chk("ramp.primed_early", 64'(bus.primed), 64'(0));
        end
        chk("ramp.q0", 64'(bus.q[7:0]), 64'(0));
        chk("ramp.qv", 64'(bus.q_valid), 64'(1));
        chk("ramp.primed", 64'(bus.primed), 64'(1));
        cycle(1'b1, 1'b0, rep(8'h10), 1'b1, AW'(15));
        chk("ramp.q1", 64'(bus.q[7:0]), 64'(1));

        // Asynchronous reset while primed, between clock edges
        #2;
        async_reset();

        // Gapped enable at D=4
        cycle(1'b0, 1'b0, '0, 1'b0, AW'(3));
        for (int i = 0; i < 8; i++)
            cycle(1'(i % 2 == 0), 1'b0, rep(8'(8'h40 + i)), 1'b1, AW'(3));
        chk("gap.q0", 64'(bus.q[7:0]), 64'(8'h40));
        chk("gap.primed", 64'(bus.primed), 64'(1));

        // Random traffic with occasional flush and tap requests
        rtap = AW'($urandom);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) rtap = AW'($urandom);
            cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 29) == 0), W'($urandom),
                  1'($urandom), rtap);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
